// File: rtl/frac_pkg.sv
// Shared definitions for the Q0.FW fraction blocks: default widths, FSM states and rounding constant.
// Widths match the Divider that produces the fractions consumed here.
package frac_pkg;
  localparam int FRAC_W = 8;
  localparam int INT_W  = 7;
  localparam int HALF   = 1 << (FRAC_W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/frac_round.sv
// Integer part of a Q(IW).(FW) value, round-half-up when ROUND != 0, truncated otherwise.
// Purely combinational; the add cannot overflow because the product never reaches 2^(IW+FW) - 2^(FW-1).
module frac_round
  import frac_pkg::*;
#(
  parameter int IW    = INT_W,
  parameter int FW    = FRAC_W,
  parameter int ROUND = 1
) (
  input  logic [IW+FW-1:0] acc,
  output logic [IW-1:0]    int_out
);

  localparam int AW = IW + FW;
  localparam logic [AW:0] RND = (ROUND != 0) ? ((AW + 1)'(1) << (FW - 1)) : '0;

  logic [AW:0] sum;
  logic        unused_bits;

  assign sum         = {1'b0, acc} + RND;
  assign int_out     = sum[AW-1:FW];
  assign unused_bits = ^{sum[AW], sum[FW-1:0]};

endmodule

// File: rtl/frac_mul.sv
// Serial shift-add multiplier: unsigned IW-bit operand times Q0.FW fraction, one fraction bit per cycle, LSB first.
// Result appears FW cycles after accept and holds under backpressure; DONE can accept the next pair on the handoff edge.
module frac_mul
  import frac_pkg::*;
#(
  parameter int IW    = INT_W,
  parameter int FW    = FRAC_W,
  parameter int ROUND = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IW-1:0]    operand,
  input  logic [FW-1:0]    frac,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IW+FW-1:0] product,
  output logic [IW-1:0]    int_out
);

  localparam int AW = IW + FW;
  localparam int CW = (FW > 1) ? $clog2(FW) : 1;
  localparam logic [CW-1:0] LAST = CW'(FW - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [AW-1:0] acc;
  logic [AW-1:0] acc_next;
  logic [AW-1:0] addend;
  logic [IW-1:0] op_reg;
  logic [FW-1:0] frac_reg;
  logic [IW-1:0] int_next;
  logic          accept;

  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;

  assign addend   = AW'(op_reg) << cnt;
  assign acc_next = frac_reg[cnt] ? (acc + addend) : acc;

  // Rounding sees acc_next so product and int_out register together on the last RUN edge.
  frac_round #(
    .IW   (IW),
    .FW   (FW),
    .ROUND(ROUND)
  ) u_round (
    .acc    (acc_next),
    .int_out(int_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      op_reg   <= '0;
      frac_reg <= '0;
      product  <= '0;
      int_out  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            op_reg   <= operand;
            frac_reg <= frac;
            acc      <= '0;
            cnt      <= '0;
            state    <= RUN;
          end else if ((state == DONE) && out_ready) begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            product <= acc_next;
            int_out <= int_next;
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
